// File: rtl/uart_pkg.sv
// uart_pkg: constants, types and helpers shared by the UART baud path.
//   UART_DIV_WIDTH  : default width of the divisor and the prescale counter
//   UART_OVERSAMPLE : default number of oversample ticks per bit
//   divisor_t       : divisor value type at the default width
//   calc_divisor()  : clk_hz / (baud * oversample), rounded to nearest
package uart_pkg;

  localparam int UART_DIV_WIDTH  = 16;
  localparam int UART_OVERSAMPLE = 16;

  typedef logic [UART_DIV_WIDTH-1:0] divisor_t;

  // Exact halves round up. A zero denominator gives 0, which the generator
  // treats as "tick every cycle".
  function automatic divisor_t calc_divisor(input longint unsigned clk_hz,
                                            input longint unsigned baud,
                                            input longint unsigned oversample);
    longint unsigned den;
    den = baud * oversample;
    if (den == 0) return '0;
    return divisor_t'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_prescaler.sv
// uart_prescaler: divides I_clk by the effective divisor max(div_q,1) and
// flags the last cycle of each prescale period.
//   I_clk      : system clock
//   I_reset_n  : asynchronous active-low reset
//   I_enable   : run enable; while low the counter is held at 0
//   I_divisor  : requested divisor, latched only at period boundaries
//   I_resync   : restart the prescale period at phase 0
//   O_wrap     : combinational, high in the last cycle of a period;
//                suppressed while disabled or resyncing
module uart_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_enable,
  input  logic [DIV_WIDTH-1:0] I_divisor,
  input  logic                 I_resync,
  output logic                 O_wrap
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_sel;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 run_q;

  // On the first enabled cycle (after reset or after a disable) the held
  // divisor may be stale (reset leaves it at 0), so the live input is used
  // for that one cycle and latched at the same time. A start with enable
  // already high out of reset therefore times exactly like a fresh enable.
  always_comb begin
    div_sel  = run_q ? div_q : I_divisor;
    div_last = (div_sel == '0) ? '0 : div_sel - DIV_WIDTH'(1);
    O_wrap   = I_enable && !I_resync && (div_cnt == div_last);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      div_q   <= '0;
      div_cnt <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= I_enable;
      if (!I_enable || I_resync || !run_q || O_wrap) begin
        div_q <= I_divisor;
      end
      if (!I_enable || I_resync || O_wrap) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud / oversample clock-enable generator for the UART path.
// Emits single-cycle ticks in the I_clk domain; no derived clock is created.
//   I_clk      : system clock, all state on the rising edge
//   I_reset_n  : asynchronous active-low reset (deassertion synchronised
//                externally)
//   I_enable   : generator run enable
//   I_divisor  : I_clk cycles per oversample tick (0 and 1 both mean 1)
//   I_resync   : restart bit phase (RX start-bit detect), ignored if disabled
//   O_os_tick  : pulse every Deff cycles
//   O_bit_tick : pulse on the last oversample tick of each bit
//   O_mid_tick : pulse on oversample tick OVERSAMPLE/2-1 (bit centre)
//   O_clk      : bit-rate square wave, high for the first half of each bit
//   O_busy     : registered I_enable
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = UART_DIV_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int OS_WIDTH   = $clog2(OVERSAMPLE)
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_enable,
  input  logic [DIV_WIDTH-1:0] I_divisor,
  input  logic                 I_resync,
  output logic                 O_os_tick,
  output logic                 O_bit_tick,
  output logic                 O_mid_tick,
  output logic                 O_clk,
  output logic                 O_busy
);

  localparam logic [OS_WIDTH-1:0] OS_LAST = OS_WIDTH'(OVERSAMPLE - 1);
  localparam logic [OS_WIDTH-1:0] OS_MID  = OS_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_WIDTH-1:0] OS_HALF = OS_WIDTH'(OVERSAMPLE / 2);

  logic                wrap;
  logic [OS_WIDTH-1:0] os_cnt;
  logic [OS_WIDTH-1:0] os_cnt_next;

  uart_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_enable  (I_enable),
    .I_divisor (I_divisor),
    .I_resync  (I_resync),
    .O_wrap    (wrap)
  );

  // wrap is already gated by enable and resync, so the tick outputs need no
  // further qualification; resync and disable only have to clear the phase.
  always_comb begin
    os_cnt_next = os_cnt;
    if (!I_enable || I_resync) begin
      os_cnt_next = '0;
    end else if (wrap) begin
      os_cnt_next = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_WIDTH'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      os_cnt     <= '0;
      O_os_tick  <= 1'b0;
      O_bit_tick <= 1'b0;
      O_mid_tick <= 1'b0;
      O_clk      <= 1'b0;
      O_busy     <= 1'b0;
    end else begin
      os_cnt     <= os_cnt_next;
      O_os_tick  <= wrap;
      O_bit_tick <= wrap && (os_cnt == OS_LAST);
      O_mid_tick <= wrap && (os_cnt == OS_MID);
      O_clk      <= I_enable && (os_cnt_next < OS_HALF);
      O_busy     <= I_enable;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed checks of uart_baud_gen at DIV_WIDTH=16,
// OVERSAMPLE=16. Cycle c of a scan is the sample taken #1 after the c-th
// rising edge following the point where the stimulus was applied.
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_reset_n = 1'b0;
  logic        I_enable = 1'b0;
  logic [15:0] I_divisor = '0;
  logic        I_resync = 1'b0;
  logic        O_os_tick, O_bit_tick, O_mid_tick, O_clk, O_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int os_at [64];
  int bit_at[8];
  int mid_at[8];
  int n_os, n_bit, n_mid, viol;
  logic clk_hist[0:255];
  logic os_hist [0:255];

  uart_baud_gen #(
    .DIV_WIDTH  (16),
    .OVERSAMPLE (16)
  ) dut (
    .I_clk      (I_clk),
    .I_reset_n  (I_reset_n),
    .I_enable   (I_enable),
    .I_divisor  (I_divisor),
    .I_resync   (I_resync),
    .O_os_tick  (O_os_tick),
    .O_bit_tick (O_bit_tick),
    .O_mid_tick (O_mid_tick),
    .O_clk      (O_clk),
    .O_busy     (O_busy)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  function automatic int outs();
    return {27'd0, O_os_tick, O_bit_tick, O_mid_tick, O_clk, O_busy};
  endfunction

  // Disable for two cycles with the new divisor, then enable (cycle 0).
  task automatic fresh(input logic [15:0] d);
    I_enable  = 1'b0;
    I_resync  = 1'b0;
    I_divisor = d;
    step();
    step();
    I_enable = 1'b1;
  endtask

  // Run n cycles recording pulse positions; optionally change the divisor
  // after cycle chg_at and pulse resync so it is sampled at cycle rs_at+1.
  task automatic scan(input int n, input int chg_at, input logic [15:0] chg_d,
                      input int rs_at);
    n_os = 0; n_bit = 0; n_mid = 0; viol = 0;
    for (int i = 0; i < 64; i++) os_at[i] = -1;
    for (int i = 0; i < 8; i++) begin
      bit_at[i] = -1;
      mid_at[i] = -1;
    end
    for (int c = 1; c <= n; c++) begin
      step();
      if (O_os_tick) begin
        if (n_os < 64) os_at[n_os] = c;
        n_os++;
      end
      if (O_bit_tick) begin
        if (n_bit < 8) bit_at[n_bit] = c;
        n_bit++;
      end
      if (O_mid_tick) begin
        if (n_mid < 8) mid_at[n_mid] = c;
        n_mid++;
      end
      if (((O_bit_tick || O_mid_tick) && !O_os_tick) || (O_bit_tick && O_mid_tick))
        viol++;
      if (c <= 255) begin
        clk_hist[c] = O_clk;
        os_hist[c]  = O_os_tick;
      end
      if (c == chg_at) I_divisor = chg_d;
      I_resync = (c == rs_at);
    end
    I_resync = 1'b0;
  endtask

  initial begin
    // Reset state
    I_divisor = 16'd4;
    #12;
    check("reset_outs", outs(), 0);
    step();
    I_reset_n = 1'b1;
    step();
    step();
    check("idle_outs", outs(), 0);

    // Helper rounding
    check("calc_div_27", int'(calc_divisor(50_000_000, 115200, 16)), 27);
    check("calc_div_313", int'(calc_divisor(48_000_000, 9600, 16)), 313);

    // D=4 fresh start
    fresh(16'd4);
    scan(130, -1, '0, -1);
    check("d4_os0", os_at[0], 4);
    check("d4_os1", os_at[1], 8);
    check("d4_os_count", n_os, 32);
    check("d4_mid0", mid_at[0], 32);
    check("d4_bit0", bit_at[0], 64);
    check("d4_mid1", mid_at[1], 96);
    check("d4_bit1", bit_at[1], 128);
    check("d4_clk1", int'(clk_hist[1]), 1);
    check("d4_clk31", int'(clk_hist[31]), 1);
    check("d4_clk32", int'(clk_hist[32]), 0);
    check("d4_clk63", int'(clk_hist[63]), 0);
    check("d4_clk64", int'(clk_hist[64]), 1);
    check("d4_clk96", int'(clk_hist[96]), 0);
    check("d4_viol", viol, 0);
    check("d4_busy", int'(O_busy), 1);

    // D=0 and D=1: tick every cycle
    fresh(16'd0);
    scan(40, -1, '0, -1);
    check("d0_os0", os_at[0], 1);
    check("d0_os_count", n_os, 40);
    check("d0_mid0", mid_at[0], 8);
    check("d0_bit0", bit_at[0], 16);
    check("d0_bit1", bit_at[1], 32);
    check("d0_viol", viol, 0);
    fresh(16'd1);
    scan(40, -1, '0, -1);
    check("d1_os_count", n_os, 40);
    check("d1_bit0", bit_at[0], 16);
    check("d1_mid1", mid_at[1], 24);

    // D=10, change to 3 at prescaler count 4 of the second period
    fresh(16'd10);
    scan(30, 14, 16'd3, -1);
    check("chg_os0", os_at[0], 10);
    check("chg_os1", os_at[1], 20);
    check("chg_os2", os_at[2], 23);
    check("chg_os3", os_at[3], 26);
    check("chg_os4", os_at[4], 29);
    check("chg_os_count", n_os, 5);

    // D=8, resync at os_cnt=5, div_cnt=7 (coincident wrap at cycle 48)
    fresh(16'd8);
    scan(180, -1, '0, 47);
    check("rs_os4", os_at[4], 40);
    check("rs_no_tick48", int'(os_hist[48]), 0);
    check("rs_os5", os_at[5], 56);
    check("rs_mid0", mid_at[0], 112);
    check("rs_bit0", bit_at[0], 176);
    check("rs_os_count", n_os, 21);
    check("rs_viol", viol, 0);

    // Async reset mid-bit (os_cnt=9), enable held high
    fresh(16'd4);
    scan(38, -1, '0, -1);
    check("pre_rst_busy", int'(O_busy), 1);
    I_reset_n = 1'b0;
    #1;
    check("async_rst_outs", outs(), 0);
    step();
    step();
    check("held_rst_outs", outs(), 0);
    I_reset_n = 1'b1;
    scan(70, -1, '0, -1);
    check("post_rst_os0", os_at[0], 4);
    check("post_rst_mid0", mid_at[0], 32);
    check("post_rst_bit0", bit_at[0], 64);

    // Disable for 3 cycles mid-bit, then re-enable
    fresh(16'd4);
    scan(20, -1, '0, -1);
    check("pre_dis_clk", int'(O_clk), 1);
    I_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("dis_outs%0d", k), outs(), 0);
    end
    I_enable = 1'b1;
    scan(70, -1, '0, -1);
    check("reen_os0", os_at[0], 4);
    check("reen_os1", os_at[1], 8);
    check("reen_mid0", mid_at[0], 32);
    check("reen_bit0", bit_at[0], 64);
    check("reen_viol", viol, 0);

    // Resync ignored while disabled
    I_enable = 1'b0;
    I_resync = 1'b1;
    step();
    step();
    check("rs_disabled_outs", outs(), 0);
    I_resync = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
